// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: finds byte alignment on a COMMA character,
// locks after LOCK_COUNT aligned COMMAs and then delivers non-COMMA bytes.
module serial_paralelo #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk8f,
  input  logic       reset_L,
  input  logic       serial,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam logic [1:0] UNALIGNED = 2'd0;
  localparam logic [1:0] COUNTING  = 2'd1;
  localparam logic [1:0] ACTIVE    = 2'd2;

  localparam logic [3:0] LOCK = 4'(LOCK_COUNT);

  logic [1:0] state;
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;
  logic [3:0] comma_cnt;
  logic [7:0] next_shift;
  logic       next_is_comma;
  logic       boundary;

  assign next_shift    = {shift_reg[6:0], serial};
  assign next_is_comma = (next_shift == COMMA);
  assign boundary      = (bit_cnt == 3'd7);

  // In ACTIVE, bit_cnt == 0 means shift_reg still holds the byte completed at
  // the previous edge, which gives the one-cycle output latency for free.
  always_ff @(posedge clk8f or negedge reset_L) begin
    if (!reset_L) begin
      state     <= UNALIGNED;
      shift_reg <= 8'h00;
      bit_cnt   <= 3'd0;
      comma_cnt <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      shift_reg <= next_shift;
      case (state)
        UNALIGNED: begin
          valid_out <= 1'b0;
          if (next_is_comma) begin
            bit_cnt   <= 3'd0;
            comma_cnt <= 4'd1;
            if (LOCK == 4'd1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= COUNTING;
            end
          end
        end
        COUNTING: begin
          valid_out <= 1'b0;
          bit_cnt   <= bit_cnt + 3'd1;
          if (boundary) begin
            if (next_is_comma) begin
              comma_cnt <= comma_cnt + 4'd1;
              if (comma_cnt + 4'd1 == LOCK) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              state     <= UNALIGNED;
              comma_cnt <= 4'd0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd0) begin
            if (shift_reg != COMMA) begin
              data_out  <= shift_reg;
              valid_out <= 1'b1;
            end else begin
              valid_out <= 1'b0;
            end
          end
        end
        default: begin
          state <= UNALIGNED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo.sv
// Randomized bench for serial_paralelo, checked every cycle against a
// byte-phase reference model.
module tb_serial_paralelo;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int         LOCK  = 4;

  logic       clk8f;
  logic       reset_L;
  logic       serial;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int checkCount;
  int errorCount;

  // Reference model state: byte phase is the global cycle number modulo 8.
  logic [7:0] mWin;
  int         mCycle;
  int         mPhase;
  int         mRun;
  logic       mReady;
  logic [7:0] mByte;
  logic [7:0] expData;
  logic       expValid;
  logic       expActive;

  serial_paralelo #(.COMMA(COMMA), .LOCK_COUNT(LOCK)) dut (
    .clk8f    (clk8f),
    .reset_L  (reset_L),
    .serial   (serial),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  initial clk8f = 1'b0;
  always #5 clk8f = ~clk8f;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mWin = 8'h00; mCycle = 0; mPhase = 0; mRun = 0; mReady = 1'b0; mByte = 8'h00;
    expData = 8'h00; expValid = 1'b0; expActive = 1'b0;
  endtask

  task automatic modelStep(input logic b);
    mCycle++;
    mWin = {mWin[6:0], b};
    if (mReady) begin
      if (mByte != COMMA) begin
        expData  = mByte;
        expValid = 1'b1;
      end else begin
        expValid = 1'b0;
      end
      mReady = 1'b0;
    end
    if (expActive) begin
      if (mCycle % 8 == mPhase) begin
        mByte  = mWin;
        mReady = 1'b1;
      end
    end else if (mRun == 0) begin
      if (mWin == COMMA) begin
        mPhase = mCycle % 8;
        mRun   = 1;
      end
    end else if (mCycle % 8 == mPhase) begin
      if (mWin == COMMA) mRun++;
      else mRun = 0;
    end
    if (!expActive && mRun >= LOCK) begin
      expActive = 1'b1;
      mByte     = mWin;
      mReady    = 1'b1;
    end
  endtask

  // Called at a negedge; drives one bit, checks after the posedge, returns at the next negedge.
  task automatic applyStimulus(input logic b, input string tag);
    serial = b;
    @(posedge clk8f);
    #1;
    modelStep(b);
    checkOutput({tag, ".data"}, data_out, expData);
    checkOutput({tag, ".valid"}, {7'd0, valid_out}, {7'd0, expValid});
    checkOutput({tag, ".active"}, {7'd0, active}, {7'd0, expActive});
    @(negedge clk8f);
  endtask

  task automatic sendByte(input logic [7:0] value, input string tag);
    for (int i = 7; i >= 0; i--) applyStimulus(value[i], tag);
  endtask

  task automatic resetPulse(input string tag);
    #3;
    reset_L = 1'b0;
    #1;
    checkOutput({tag, ".rst_data"}, data_out, 8'h00);
    checkOutput({tag, ".rst_valid"}, {7'd0, valid_out}, 8'h00);
    checkOutput({tag, ".rst_active"}, {7'd0, active}, 8'h00);
    @(negedge clk8f);
    @(negedge clk8f);
    reset_L = 1'b1;
    modelReset();
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    serial  = 1'b0;
    reset_L = 1'b0;
    modelReset();
    @(negedge clk8f);
    @(negedge clk8f);
    checkOutput("init.data", data_out, 8'h00);
    checkOutput("init.valid", {7'd0, valid_out}, 8'h00);
    checkOutput("init.active", {7'd0, active}, 8'h00);
    reset_L = 1'b1;
    modelReset();

    // Lock, two data bytes, then idle and a single data byte.
    for (int k = 0; k < 4; k++) sendByte(COMMA, "lock");
    checkOutput("lock.active_now", {7'd0, active}, 8'h01);
    sendByte(8'hA5, "lock");
    sendByte(8'h3C, "lock");
    checkOutput("lock.a5_held", data_out, 8'hA5);
    sendByte(COMMA, "lock");
    checkOutput("lock.3c", data_out, 8'h3C);
    checkOutput("lock.3c_valid", {7'd0, valid_out}, 8'h01);
    sendByte(8'h77, "idle");
    checkOutput("idle.hold", data_out, 8'h3C);
    checkOutput("idle.novalid", {7'd0, valid_out}, 8'h00);
    sendByte(COMMA, "idle");
    checkOutput("idle.77", data_out, 8'h77);
    applyStimulus(1'b1, "idle");
    checkOutput("idle.77_kept", data_out, 8'h77);
    checkOutput("idle.77_gone", {7'd0, valid_out}, 8'h00);

    // Reset mid-byte while locked, then relock from scratch.
    applyStimulus(1'b0, "midbyte");
    applyStimulus(1'b1, "midbyte");
    resetPulse("midreset");
    for (int k = 0; k < 3; k++) sendByte(COMMA, "relock");
    checkOutput("relock.not_yet", {7'd0, active}, 8'h00);
    sendByte(COMMA, "relock");
    checkOutput("relock.active", {7'd0, active}, 8'h01);

    // Misaligned start.
    resetPulse("misalign");
    applyStimulus(1'b1, "garbage");
    applyStimulus(1'b0, "garbage");
    applyStimulus(1'b1, "garbage");
    for (int k = 0; k < 4; k++) sendByte(COMMA, "misalign");
    sendByte(8'h5A, "misalign");
    sendByte(COMMA, "misalign");
    checkOutput("misalign.5a", data_out, 8'h5A);

    // Incomplete lock.
    resetPulse("incomplete");
    for (int k = 0; k < 3; k++) sendByte(COMMA, "incomplete");
    sendByte(8'h11, "incomplete");
    sendByte(8'h22, "incomplete");
    checkOutput("incomplete.active", {7'd0, active}, 8'h00);
    checkOutput("incomplete.valid", {7'd0, valid_out}, 8'h00);

    // Back-to-back data.
    resetPulse("b2b");
    for (int k = 0; k < 4; k++) sendByte(COMMA, "b2b");
    sendByte(8'h00, "b2b");
    sendByte(8'hFF, "b2b");
    sendByte(8'hBD, "b2b");
    sendByte(COMMA, "b2b");
    checkOutput("b2b.bd", data_out, 8'hBD);

    // Random rounds: garbage bits, a possibly short comma run, then mixed traffic.
    for (int r = 0; r < 30; r++) begin
      resetPulse("rnd");
      for (int g = 0; g < int'($urandom_range(0, 7)); g++) applyStimulus(1'($urandom_range(0, 1)), "rnd_g");
      for (int k = 0; k < int'($urandom_range(2, 5)); k++) sendByte(COMMA, "rnd_c");
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 3) == 0) sendByte(COMMA, "rnd_d");
        else sendByte(8'($urandom), "rnd_d");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
